// File: rtl/product_scatter_xbar_pkg.sv
// Shared types and sizes for the product scatter crossbar and its neighbours.
package product_scatter_xbar_pkg;

   localparam int unsigned F        = 4;
   localparam int unsigned I        = 4;
   localparam int unsigned LANES    = F * I;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned NUM_BANK = 32;
   localparam int unsigned BANK_W   = $clog2(NUM_BANK);
   localparam int unsigned ADDR_W   = 8;

   // Product batch as it leaves the multiplier array.
   typedef struct packed {
      logic [LANES-1:0][DATA_W-1:0] output_data;
      logic [LANES-1:0]             valid;
   } MUL_DATA;

   // One cycle of accumulator bank writes.
   typedef struct packed {
      logic [NUM_BANK-1:0]             valid;
      logic [NUM_BANK-1:0][DATA_W-1:0] data;
      logic [NUM_BANK-1:0][ADDR_W-1:0] addr;
   } XBAR_ACC;

endpackage

// File: rtl/product_scatter_xbar_lane_prio_arb.sv
// Fixed-priority arbiter: the lowest-index requesting lane wins.
module lane_prio_arb
   import product_scatter_xbar_pkg::*;
(
   input  logic [LANES-1:0] req,
   output logic [LANES-1:0] grant
);

   // Isolate the least significant set bit of the request vector.
   assign grant = req & (~req + LANES'(1));

endmodule

// File: rtl/product_scatter_xbar.sv
// Scatters one batch of products per cycle to the accumulator banks,
// serialising lanes that collide on a bank and stalling upstream meanwhile.
module product_scatter_xbar
   import product_scatter_xbar_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  MUL_DATA                           MUL_XBAR_OUT,
   input  logic                              reg_MA_Partial_c,
   input  logic [LANES-1:0][BANK_W-1:0]      lane_bank,
   input  logic [LANES-1:0][ADDR_W-1:0]      lane_addr,
   output logic                              stall,
   output logic [NUM_BANK-1:0]               acc_valid,
   output logic [NUM_BANK-1:0][DATA_W-1:0]   acc_data,
   output logic [NUM_BANK-1:0][ADDR_W-1:0]   acc_addr,
   output logic                              partial_done
);

   logic [LANES-1:0]              pend_valid;
   logic [LANES-1:0][DATA_W-1:0]  pend_data;
   logic [LANES-1:0][BANK_W-1:0]  pend_bank;
   logic [LANES-1:0][ADDR_W-1:0]  pend_addr;
   logic                          pend_pc;

   logic [NUM_BANK-1:0][LANES-1:0] bank_req;
   logic [NUM_BANK-1:0][LANES-1:0] bank_grant;
   logic [LANES-1:0]               grant;
   logic [LANES-1:0]               remain;
   XBAR_ACC                        acc_d;
   XBAR_ACC                        acc_q;

   // Per-bank request vectors from the pending lanes.
   always_comb begin
      bank_req = '0;
      for (int unsigned b = 0; b < NUM_BANK; b++) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            bank_req[b][l] = pend_valid[l] && (pend_bank[l] == BANK_W'(b));
         end
      end
   end

   genvar gb;
   generate
      for (gb = 0; gb < NUM_BANK; gb++) begin : g_arb
         lane_prio_arb u_arb (
            .req   (bank_req[gb]),
            .grant (bank_grant[gb])
         );
      end
   endgenerate

   // Route each bank's granted lane to its write port and collect lane grants.
   always_comb begin
      grant = '0;
      acc_d = '0;
      for (int unsigned b = 0; b < NUM_BANK; b++) begin
         acc_d.valid[b] = |bank_grant[b];
         for (int unsigned l = 0; l < LANES; l++) begin
            if (bank_grant[b][l]) begin
               grant[l]      = 1'b1;
               acc_d.data[b] = pend_data[l];
               acc_d.addr[b] = pend_addr[l];
            end
         end
      end
   end

   assign remain = pend_valid & ~grant;
   assign stall  = |remain;

   // Pending register file: capture a new batch once the current one drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= '0;
         pend_data  <= '0;
         pend_bank  <= '0;
         pend_addr  <= '0;
         pend_pc    <= 1'b0;
      end else if (!stall) begin
         pend_valid <= MUL_XBAR_OUT.valid;
         pend_data  <= MUL_XBAR_OUT.output_data;
         pend_bank  <= lane_bank;
         pend_addr  <= lane_addr;
         pend_pc    <= reg_MA_Partial_c;
      end else begin
         pend_valid <= remain;
      end
   end

   // Registered bank writes and end-of-partial-group pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q        <= '0;
         partial_done <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         partial_done <= pend_pc && !stall;
      end
   end

   assign acc_valid = acc_q.valid;
   assign acc_data  = acc_q.data;
   assign acc_addr  = acc_q.addr;

endmodule
